// File: rtl/line_octant_setup_if.sv
// Line setup request/result bundle: request side from the line source, result side to the point generator.
interface line_octant_setup_if #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int EW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic          clr_color;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] x_start;
  logic [XW-1:0] y_start;
  logic [XW-1:0] x_end;
  logic [XW-1:0] dx;
  logic [XW-1:0] dy;
  logic [EW-1:0] err_init;
  logic          x_dir;
  logic          y_dir;
  logic [2:0]    octant;
  logic          clr_out;

  modport master (
    output in_valid, x0, x1, y0, y1, clr_color, out_ready,
    input  in_ready, out_valid, x_start, y_start, x_end, dx, dy,
           err_init, x_dir, y_dir, octant, clr_out
  );

  modport slave (
    input  in_valid, x0, x1, y0, y1, clr_color, out_ready,
    output in_ready, out_valid, x_start, y_start, x_end, dx, dy,
           err_init, x_dir, y_dir, octant, clr_out
  );
endinterface

// File: rtl/line_octant_setup.sv
// Line rasterizer front end: octant classification, steep-line axis swap and Bresenham setup.
// Optional macro POINT_FASTPATH_EN sends zero-length lines straight from CLASSIFY to PRESENT.
//
// state    | meaning
// IDLE     | waiting for a line, in_ready high
// CLASSIFY | |dx|, |dy|, signs, steepness and octant code from captured endpoints
// SWAP     | map into generator space (x/y swapped for steep lines unless clearing)
// CALC     | initial error term 2*dy - dx
// PRESENT  | result held with out_valid until the generator takes it
module line_octant_setup #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int EW = 12
) (
  input logic                 i_clk,
  input logic                 i_rst,
  line_octant_setup_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLASSIFY = 3'd1,
    S_SWAP     = 3'd2,
    S_CALC     = 3'd3,
    S_PRESENT  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XW-1:0] r_x0, r_x1;
  logic [YW-1:0] r_y0, r_y1;
  logic          r_clr;

  logic [XW-1:0] r_adx, r_ady;
  logic          r_xneg, r_yneg, r_steep;
  logic [2:0]    r_octant;

  logic [XW-1:0] r_x_start, r_y_start, r_x_end, r_dx, r_dy;
  logic [EW-1:0] r_err;
  logic          r_x_dir, r_y_dir;

  logic          w_accept;
  logic          w_xneg, w_yneg, w_steep;
  logic [XW-1:0] w_adx;
  logic [YW-1:0] w_ady;
  logic [XW-1:0] w_ady_ext;
  logic          w_swap;
  logic [EW-1:0] w_err;

  assign w_accept  = (r_state == S_IDLE) && bus.in_valid && !i_rst;
  assign w_xneg    = r_x1 < r_x0;
  assign w_yneg    = r_y1 < r_y0;
  assign w_adx     = w_xneg ? (r_x0 - r_x1) : (r_x1 - r_x0);
  assign w_ady     = w_yneg ? (r_y0 - r_y1) : (r_y1 - r_y0);
  assign w_ady_ext = {{(XW-YW){1'b0}}, w_ady};
  assign w_steep   = w_ady_ext > w_adx;
  assign w_swap    = r_steep && !r_clr;
  // 2*dy fits in EW-1 bits, so the subtraction never wraps
  assign w_err     = {{(EW-XW-1){1'b0}}, r_dy, 1'b0} - {{(EW-XW){1'b0}}, r_dx};

`ifdef POINT_FASTPATH_EN
  logic w_point;
  assign w_point = (r_x0 == r_x1) && (r_y0 == r_y1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = S_CLASSIFY;
      S_CLASSIFY: begin
`ifdef POINT_FASTPATH_EN
        w_state_nxt = w_point ? S_PRESENT : S_SWAP;
`else
        w_state_nxt = S_SWAP;
`endif
      end
      S_SWAP:     w_state_nxt = S_CALC;
      S_CALC:     w_state_nxt = S_PRESENT;
      S_PRESENT:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x0      <= '0;
      r_x1      <= '0;
      r_y0      <= '0;
      r_y1      <= '0;
      r_clr     <= 1'b0;
      r_adx     <= '0;
      r_ady     <= '0;
      r_xneg    <= 1'b0;
      r_yneg    <= 1'b0;
      r_steep   <= 1'b0;
      r_octant  <= '0;
      r_x_start <= '0;
      r_y_start <= '0;
      r_x_end   <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_err     <= '0;
      r_x_dir   <= 1'b0;
      r_y_dir   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x0  <= bus.x0;
            r_x1  <= bus.x1;
            r_y0  <= bus.y0;
            r_y1  <= bus.y1;
            r_clr <= bus.clr_color;
          end
        end
        S_CLASSIFY: begin
          r_adx    <= w_adx;
          r_ady    <= w_ady_ext;
          r_xneg   <= w_xneg;
          r_yneg   <= w_yneg;
          r_steep  <= w_steep;
          r_octant <= {w_yneg, w_xneg, (w_steep ? w_xneg : !w_xneg)};
`ifdef POINT_FASTPATH_EN
          if (w_point) begin
            r_x_start <= r_x0;
            r_y_start <= {{(XW-YW){1'b0}}, r_y0};
            r_x_end   <= r_x0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_err     <= '0;
            r_x_dir   <= 1'b0;
            r_y_dir   <= 1'b0;
          end
`endif
        end
        S_SWAP: begin
          if (w_swap) begin
            r_x_start <= {{(XW-YW){1'b0}}, r_y0};
            r_y_start <= r_x0;
            r_x_end   <= {{(XW-YW){1'b0}}, r_y1};
            r_dx      <= r_ady;
            r_dy      <= r_adx;
            r_x_dir   <= r_yneg;
            r_y_dir   <= r_xneg;
          end else begin
            r_x_start <= r_x0;
            r_y_start <= {{(XW-YW){1'b0}}, r_y0};
            r_x_end   <= r_x1;
            r_dx      <= r_adx;
            r_dy      <= r_ady;
            r_x_dir   <= r_xneg;
            r_y_dir   <= r_yneg;
          end
        end
        S_CALC:  r_err <= w_err;
        default: ;
      endcase
    end
  end

  // in_ready drops combinationally with rst so no request is taken during reset
  assign bus.in_ready  = (r_state == S_IDLE) && !i_rst;
  assign bus.out_valid = (r_state == S_PRESENT);
  assign bus.x_start   = r_x_start;
  assign bus.y_start   = r_y_start;
  assign bus.x_end     = r_x_end;
  assign bus.dx        = r_dx;
  assign bus.dy        = r_dy;
  assign bus.err_init  = r_err;
  assign bus.x_dir     = r_x_dir;
  assign bus.y_dir     = r_y_dir;
  assign bus.octant    = r_octant;
  assign bus.clr_out   = r_clr;

endmodule

// File: tb/tb_line_octant_setup.sv
// Self-checking bench for line_octant_setup: directed vector table, handshake/reset sequences, random lines vs model.
module tb_line_octant_setup;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_octant_setup_if bus ();

  line_octant_setup dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int x0, y0, x1, y1, clr;
    int xs, ys, xe, dx, dy, err, xdir, ydir, oct;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the endpoints.
  task automatic model(input int x0, input int y0, input int x1, input int y1,
                       input int clr, output vec_t e);
    int adx, ady, xneg, yneg, steep;
    xneg  = (x1 < x0) ? 1 : 0;
    yneg  = (y1 < y0) ? 1 : 0;
    adx   = (x1 > x0) ? x1 - x0 : x0 - x1;
    ady   = (y1 > y0) ? y1 - y0 : y0 - y1;
    steep = (ady > adx) ? 1 : 0;
    e.x0 = x0; e.y0 = y0; e.x1 = x1; e.y1 = y1; e.clr = clr;
    if (steep == 1 && clr == 0) begin
      e.xs = y0; e.ys = x0; e.xe = y1; e.dx = ady; e.dy = adx;
      e.xdir = yneg; e.ydir = xneg;
    end else begin
      e.xs = x0; e.ys = y0; e.xe = x1; e.dx = adx; e.dy = ady;
      e.xdir = xneg; e.ydir = yneg;
    end
    e.err = 2 * e.dy - e.dx;
    e.oct = 4 * yneg + 2 * xneg + ((steep == 1) ? xneg : 1 - xneg);
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, ".x_start"}, int'(bus.x_start), e.xs);
    check({tag, ".y_start"}, int'(bus.y_start), e.ys);
    check({tag, ".x_end"},   int'(bus.x_end),   e.xe);
    check({tag, ".dx"},      int'(bus.dx),      e.dx);
    check({tag, ".dy"},      int'(bus.dy),      e.dy);
    check({tag, ".err"},     int'($signed(bus.err_init)), e.err);
    check({tag, ".x_dir"},   int'(bus.x_dir),   e.xdir);
    check({tag, ".y_dir"},   int'(bus.y_dir),   e.ydir);
    check({tag, ".octant"},  int'(bus.octant),  e.oct);
    check({tag, ".clr_out"}, int'(bus.clr_out), e.clr);
  endtask

  task automatic run_line(input vec_t e, input int hold, input string tag);
    int lat;
    int exp_lat;
    exp_lat = 3;
`ifdef POINT_FASTPATH_EN
    if (e.x0 == e.x1 && e.y0 == e.y1) exp_lat = 1;
`endif
    @(negedge clk);
    bus.x0        = e.x0[9:0];
    bus.y0        = e.y0[8:0];
    bus.x1        = e.x1[9:0];
    bus.y1        = e.y1[8:0];
    bus.clr_color = e.clr[0];
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    check({tag, ".in_ready_idle"}, int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    if (bus.out_valid) check_outputs(tag, e);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.x0 = 10'($urandom_range(0, 639));
      bus.y1 = 9'($urandom_range(0, 479));
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, int'(bus.out_valid), 1);
      check({tag, ".hold_in_ready"}, int'(bus.in_ready), 0);
      check({tag, ".hold_x_start"}, int'(bus.x_start), e.xs);
      check({tag, ".hold_dx"}, int'(bus.dx), e.dx);
      check({tag, ".hold_err"}, int'($signed(bus.err_init)), e.err);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".done_valid"}, int'(bus.out_valid), 0);
    check({tag, ".done_in_ready"}, int'(bus.in_ready), 1);
  endtask

  vec_t tbl[10];
  vec_t e;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.clr_color = 1'b0;
    bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;

    //             x0   y0   x1   y1 clr   xs   ys   xe   dx   dy   err xd yd oct
    tbl[0] = '{  10,  20,  30,  25, 0,   10,  20,  30,  20,   5,  -10, 0, 0, 1};
    tbl[1] = '{  10,  20,  13,  60, 0,   20,  10,  60,  40,   3,  -34, 0, 0, 0};
    tbl[2] = '{ 100, 100,  40,  90, 0,  100, 100,  40,  60,  10,  -40, 1, 1, 6};
    tbl[3] = '{  10,  20,  13,  60, 1,   10,  20,  13,   3,  40,   77, 0, 0, 0};
    tbl[4] = '{   5,   5,   5,   5, 0,    5,   5,   5,   0,   0,    0, 0, 0, 1};
    tbl[5] = '{   0,   0,   7,   7, 0,    0,   0,   7,   7,   7,    7, 0, 0, 1};
    tbl[6] = '{   0,   0, 639,   0, 0,    0,   0, 639, 639,   0, -639, 0, 0, 1};
    tbl[7] = '{  50, 100,  40,   0, 0,  100,  50,   0, 100,  10,  -80, 1, 1, 7};
    tbl[8] = '{ 639, 479,   0,   0, 0,  639, 479,   0, 639, 479,  319, 1, 1, 6};
    tbl[9] = '{   0, 479,   0,   0, 1,    0, 479,   0,   0, 479,  958, 0, 1, 4};

    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", int'(bus.in_ready), 0);
    check("rst.out_valid", int'(bus.out_valid), 0);
    check("rst.x_start", int'(bus.x_start), 0);
    check("rst.dx", int'(bus.dx), 0);
    check("rst.err", int'(bus.err_init), 0);
    check("rst.octant", int'(bus.octant), 0);
    check("rst.clr_out", int'(bus.clr_out), 0);
    rst = 1'b0;
    #1;
    check("rst.in_ready_release", int'(bus.in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      run_line(tbl[i], 0, $sformatf("vec%0d", i));
    end

    run_line(tbl[0], 5, "stall");

    // reset while the line sits in SWAP
    @(negedge clk);
    bus.x0 = 10'd100; bus.y0 = 9'd7; bus.x1 = 10'd300; bus.y1 = 9'd400;
    bus.clr_color = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid.in_ready", int'(bus.in_ready), 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_mid.out_valid", int'(bus.out_valid), 0);
    end
    check("rst_mid.clr_out", int'(bus.clr_out), 0);
    rst = 1'b0;
    #1;
    check("rst_mid.in_ready_release", int'(bus.in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_mid.no_result", int'(bus.out_valid), 0);
    end
    model(200, 300, 150, 100, 0, e);
    run_line(e, 0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      int x0, y0, x1, y1, clr;
      x0 = $urandom_range(0, 639);
      y0 = $urandom_range(0, 479);
      x1 = $urandom_range(0, 639);
      y1 = $urandom_range(0, 479);
      clr = $urandom_range(0, 1);
      if (i % 8 == 0) x1 = x0;
      if (i % 8 == 1) y1 = y0;
      if (i % 10 == 3) begin x1 = x0; y1 = y0; end
      if (i % 8 == 5) y1 = (y0 + ((x1 > x0) ? x1 - x0 : x0 - x1)) % 480;
      model(x0, y0, x1, y1, clr, e);
      run_line(e, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
